// File: rtl/wb_pkg.sv
// Shared types and sizes for the writeback arbiter.
//   AW         register address width (32 registers)
//   DW         result data width
//   NREG       number of architectural registers tracked by the scoreboard
//   wb_entry_t one buffered writeback: destination register + data
package wb_pkg;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;

    typedef struct packed {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous circular FIFO of writeback entries.
//   clk      clock, rising edge
//   reset_n  asynchronous active-low reset (empties the FIFO)
//   push     write wr_data at the tail; ignored when full
//   wr_data  entry to enqueue
//   pop      drop the head entry; ignored when empty
//   rd_data  current head entry (combinational read)
//   count    current occupancy, 0..DEPTH
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  wb_entry_t                wr_data,
    input  logic                     pop,
    output wb_entry_t                rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A push is refused when full even if a pop frees a slot this cycle.
    assign do_push = push && (count != FULL_CNT);
    assign do_pop  = pop && (count != '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: owns the register-file write port and merges ALU
// results (absolute priority, no backpressure) with buffered MDU results.
//   clk, reset_n      clock / asynchronous active-low reset
//   alu_valid/wa/wd   single-cycle ALU result
//   mdu_valid/wa/wd   MDU result offer; mdu_ready = FIFO not full
//   issue_valid/wa    long-latency op issued; marks its destination pending
//   rf_we/wa/wd       registered register-file write port
//   pending           per-register outstanding-MDU-write scoreboard
//   fifo_count        MDU FIFO occupancy
//   drain_req         FIFO head starved; asks decode for one ALU bubble
//   waw_err           sticky: ALU wrote a register with an MDU write pending
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_wa,
    input  logic [DW-1:0]            alu_wd,
    input  logic                     mdu_valid,
    output logic                     mdu_ready,
    input  logic [AW-1:0]            mdu_wa,
    input  logic [DW-1:0]            mdu_wd,
    input  logic                     issue_valid,
    input  logic [AW-1:0]            issue_wa,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_wa,
    output logic [DW-1:0]            rf_wd,
    output logic [NREG-1:0]          pending,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     drain_req,
    output logic                     waw_err
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_LOAD = SW'(STARVE_LIMIT);

    wb_entry_t        head;
    wb_entry_t        push_data;
    logic             push;
    logic             pop;
    logic             alu_wr;
    logic             fifo_empty;
    logic             stalled;
    logic [SW-1:0]    starve_tmr;
    logic [NREG-1:0]  pending_nxt;

    assign push_data  = '{wa: mdu_wa, wd: mdu_wd};
    assign mdu_ready  = (fifo_count != FULL_CNT);
    assign push       = mdu_valid && mdu_ready;
    assign fifo_empty = (fifo_count == '0);

    // An ALU result to r0 is a no-write and leaves the port to the FIFO.
    assign alu_wr  = alu_valid && (alu_wa != '0);
    assign pop     = !alu_wr && !fifo_empty;
    assign stalled = !fifo_empty && !pop;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wr_data (push_data),
        .pop     (pop),
        .rd_data (head),
        .count   (fifo_count)
    );

    // A new issue to the register being retired this cycle must stay pending.
    always_comb begin
        pending_nxt = pending;
        if (pop) begin
            pending_nxt[head.wa] = 1'b0;
        end
        if (issue_valid) begin
            pending_nxt[issue_wa] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_we   <= 1'b0;
            rf_wa   <= '0;
            rf_wd   <= '0;
            pending <= '0;
            waw_err <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (alu_wr && pending[alu_wa]) begin
                waw_err <= 1'b1;
            end
            if (alu_wr) begin
                rf_we <= 1'b1;
                rf_wa <= alu_wa;
                rf_wd <= alu_wd;
            end else if (pop) begin
                rf_we <= (head.wa != '0);
                rf_wa <= head.wa;
                rf_wd <= head.wd;
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

    // Starve timer counts down the remaining stalled cycles; reload means
    // "no stall time elapsed". Terminal count (0) means STARVE_LIMIT stalled
    // cycles have passed, and drain_req follows one edge later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_tmr <= STARVE_LOAD;
            drain_req  <= 1'b0;
        end else begin
            if (!stalled) begin
                starve_tmr <= STARVE_LOAD;
            end else if (starve_tmr != '0) begin
                starve_tmr <= starve_tmr - SW'(1);
            end
            if (pop) begin
                drain_req <= 1'b0;
            end else if (starve_tmr == '0) begin
                drain_req <= 1'b1;
            end
        end
    end

endmodule
